// File: rtl/ysyx_24100027_pcunit.sv
// Program-counter unit: holds the PC, issues fetch requests and computes the next PC on commit.
// Optional misaligned-target trap into HALT is enabled by defining YSYX_24100027_PCU_ALIGN_CHK_EN.
module ysyx_24100027_pcunit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PCActr,
   input  logic        PCBctr,
   input  logic [31:0] imm,
   input  logic [31:0] rs1,
   input  logic        commit_valid,
   input  logic        trap_valid,
   input  logic [31:0] trap_pc,
   input  logic        fetch_ready,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] pc,
   output logic [31:0] snpc,
   output logic [63:0] retire_cnt,
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
   output logic        misalign,
`endif
   output logic [1:0]  dbg_state
);

   // Handshake: a fetch transfers on a cycle where fetch_valid and fetch_ready are both high;
   // fetch_valid stays high and fetch_pc stays stable until that cycle.
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
      ,HALT = 2'd2
`endif
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [63:0] cnt_q, cnt_d;
   logic        fetch_valid_q, fetch_valid_d;
   logic [31:0] op_a, op_b, sum, dnpc;
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
   logic        misalign_q, misalign_d;
`endif

   // jalr targets have bit 0 cleared; other paths keep the raw sum.
   always_comb begin
      op_a = PCActr ? imm : 32'd4;
      op_b = PCBctr ? rs1 : pc_q;
      sum  = op_a + op_b;
      dnpc = {sum[31:1], sum[0] & ~PCBctr};
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
      misalign_d = misalign_q;
`endif
      case (state_q)
         FETCH: begin
            if (fetch_valid_q && fetch_ready) state_d = WAIT;
         end
         WAIT: begin
            if (trap_valid) begin
               pc_d    = trap_pc;
               state_d = FETCH;
            end else if (commit_valid) begin
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
               if (dnpc[1:0] != 2'b00) begin
                  state_d    = HALT;
                  misalign_d = 1'b1;
               end else
`endif
               begin
                  pc_d    = dnpc;
                  cnt_d   = cnt_q + 64'd1;
                  state_d = FETCH;
               end
            end
         end
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
         HALT: state_d = HALT;
`endif
         default: state_d = FETCH;
      endcase
      fetch_valid_d = (state_d == FETCH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         cnt_q         <= 64'd0;
         fetch_valid_q <= 1'b1;
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
         misalign_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         cnt_q         <= cnt_d;
         fetch_valid_q <= fetch_valid_d;
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
         misalign_q    <= misalign_d;
`endif
      end
   end

   assign fetch_valid = fetch_valid_q;
   assign pc          = pc_q;
   assign fetch_pc    = pc_q;
   assign snpc        = pc_q + 32'd4;
   assign retire_cnt  = cnt_q;
   assign dbg_state   = state_q;
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
   assign misalign    = misalign_q;
`endif

endmodule

// File: tb/tb_ysyx_24100027_pcunit.sv
// Bench for ysyx_24100027_pcunit: directed scenarios plus random traffic against a behavioural model.
// Follows YSYX_24100027_PCU_ALIGN_CHK_EN the same way the design does.
module tb_ysyx_24100027_pcunit;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        PCActr = 0, PCBctr = 0, commit_valid = 0, trap_valid = 0, fetch_ready = 0;
   logic [31:0] imm = 0, rs1 = 0, trap_pc = 0;
   logic        fetch_valid;
   logic [31:0] fetch_pc, pc, snpc;
   logic [63:0] retire_cnt;
   logic [1:0]  dbg_state;
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
   logic        misalign;
`endif

   ysyx_24100027_pcunit dut (
      .clk(clk), .rst(rst), .PCActr(PCActr), .PCBctr(PCBctr), .imm(imm), .rs1(rs1),
      .commit_valid(commit_valid), .trap_valid(trap_valid), .trap_pc(trap_pc),
      .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .pc(pc),
      .snpc(snpc), .retire_cnt(retire_cnt),
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
      .misalign(misalign),
`endif
      .dbg_state(dbg_state)
   );

   int pass_cnt = 0;
   int total_cnt = 0;

   // reference model: architectural view of the unit
   logic [31:0] m_pc = RST_PC;
   logic [63:0] m_cnt = 0;
   bit          m_fetch = 1, m_halt = 0, m_mis = 0;

   function automatic logic [31:0] model_dnpc();
      logic [31:0] t;
      t = (PCActr ? imm : 32'd4) + (PCBctr ? rs1 : m_pc);
      if (PCBctr) t = t & ~32'd1;
      return t;
   endfunction

   // advance the model by one clock edge using the inputs currently driven, then move the DUT
   task automatic tick();
      logic [31:0] d;
      d = model_dnpc();
      if (rst) begin
         m_pc = RST_PC; m_cnt = 0; m_fetch = 1; m_halt = 0; m_mis = 0;
      end else if (!m_halt) begin
         if (m_fetch) begin
            if (fetch_ready) m_fetch = 0;
         end else if (trap_valid) begin
            m_pc = trap_pc; m_fetch = 1;
         end else if (commit_valid) begin
            if (ALIGN && d[1:0] != 2'b00) begin
               m_halt = 1; m_mis = 1;
            end else begin
               m_pc = d; m_cnt = m_cnt + 1; m_fetch = 1;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic clear_inputs();
      PCActr = 0; PCBctr = 0; commit_valid = 0; trap_valid = 0; fetch_ready = 0;
      imm = 0; rs1 = 0; trap_pc = 0;
   endtask

   task automatic handshake();
      fetch_ready = 1; tick(); fetch_ready = 0;
   endtask

   // from FETCH: land in FETCH with pc = addr via a trap redirect
   task automatic goto_pc(input logic [31:0] addr);
      handshake();
      trap_valid = 1; trap_pc = addr; tick();
      trap_valid = 0; trap_pc = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1; tick(); tick(); rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      total_cnt++; if (fetch_valid !== 1'b1) $display("FAIL reset_fetch_valid got %0b want 1", fetch_valid); else pass_cnt++;
      total_cnt++; if (fetch_pc !== RST_PC) $display("FAIL reset_fetch_pc got %h want %h", fetch_pc, RST_PC); else pass_cnt++;
      total_cnt++; if (retire_cnt !== 64'd0) $display("FAIL reset_retire_cnt got %0d want 0", retire_cnt); else pass_cnt++;
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
      total_cnt++; if (misalign !== 1'b0) $display("FAIL reset_misalign got %0b want 0", misalign); else pass_cnt++;
`endif
      for (int i = 0; i < 5; i++) begin
         tick();
         total_cnt++;
         if (fetch_pc !== RST_PC || fetch_valid !== 1'b1)
            $display("FAIL stall_hold cycle %0d got pc=%h v=%0b want pc=%h v=1", i, fetch_pc, fetch_valid, RST_PC);
         else pass_cnt++;
      end
      goto_pc(32'h8000_0040);
      handshake();
      total_cnt++; if (fetch_valid !== 1'b0) $display("FAIL wait_fetch_valid got %0b want 0", fetch_valid); else pass_cnt++;
      rst = 1; #1;
      total_cnt++; if (pc !== RST_PC || fetch_valid !== 1'b1)
         $display("FAIL async_reset got pc=%h v=%0b want pc=%h v=1", pc, fetch_valid, RST_PC);
      else pass_cnt++;
      tick(); rst = 0;
   endtask

   task automatic test_sequential();
      do_reset();
      handshake();
      commit_valid = 1; tick(); commit_valid = 0;
      total_cnt++; if (fetch_pc !== 32'h8000_0004) $display("FAIL seq_fetch_pc got %h want 80000004", fetch_pc); else pass_cnt++;
      total_cnt++; if (fetch_valid !== 1'b1) $display("FAIL seq_fetch_valid got %0b want 1", fetch_valid); else pass_cnt++;
      total_cnt++; if (retire_cnt !== 64'd1) $display("FAIL seq_retire_cnt got %0d want 1", retire_cnt); else pass_cnt++;
      total_cnt++; if (snpc !== 32'h8000_0008) $display("FAIL seq_snpc got %h want 80000008", snpc); else pass_cnt++;
   endtask

   task automatic test_branch();
      do_reset();
      goto_pc(32'h8000_0010);
      handshake();
      PCActr = 1; imm = 32'hFFFF_FFF0; commit_valid = 1; tick(); clear_inputs();
      total_cnt++; if (pc !== 32'h8000_0000) $display("FAIL branch_back got %h want 80000000", pc); else pass_cnt++;
      handshake();
      PCActr = 1; PCBctr = 1; rs1 = 32'h8000_0101; imm = 32'd4; commit_valid = 1; tick(); clear_inputs();
      total_cnt++; if (pc !== 32'h8000_0104) $display("FAIL jalr_bit0 got %h want 80000104", pc); else pass_cnt++;
      total_cnt++; if (retire_cnt !== 64'd2) $display("FAIL branch_retire got %0d want 2", retire_cnt); else pass_cnt++;
   endtask

   task automatic test_wrap();
      do_reset();
      goto_pc(32'hFFFF_FFFC);
      total_cnt++; if (snpc !== 32'h0000_0000) $display("FAIL wrap_snpc got %h want 00000000", snpc); else pass_cnt++;
      handshake();
      commit_valid = 1; tick(); commit_valid = 0;
      total_cnt++; if (pc !== 32'h0000_0000) $display("FAIL wrap_pc got %h want 00000000", pc); else pass_cnt++;
   endtask

   task automatic test_trap_priority();
      logic [63:0] cnt0;
      do_reset();
      handshake();
      commit_valid = 1; tick(); commit_valid = 0;
      cnt0 = m_cnt;
      handshake();
      trap_valid = 1; commit_valid = 1; trap_pc = 32'h8000_1000; tick(); clear_inputs();
      total_cnt++; if (pc !== 32'h8000_1000) $display("FAIL trap_pc got %h want 80001000", pc); else pass_cnt++;
      total_cnt++; if (retire_cnt !== cnt0) $display("FAIL trap_retire got %0d want %0d", retire_cnt, cnt0); else pass_cnt++;
      trap_valid = 1; commit_valid = 1; trap_pc = 32'h1234_5678; tick(); clear_inputs();
      total_cnt++; if (pc !== 32'h8000_1000 || fetch_valid !== 1'b1 || retire_cnt !== cnt0)
         $display("FAIL fetch_ignore got pc=%h v=%0b cnt=%0d want pc=80001000 v=1 cnt=%0d", pc, fetch_valid, retire_cnt, cnt0);
      else pass_cnt++;
   endtask

   task automatic test_misalign();
      do_reset();
      handshake();
      PCActr = 1; PCBctr = 1; rs1 = 32'h8000_0002; imm = 32'd0; commit_valid = 1; tick(); clear_inputs();
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
      total_cnt++; if (misalign !== 1'b1) $display("FAIL mis_flag got %0b want 1", misalign); else pass_cnt++;
      total_cnt++; if (fetch_valid !== 1'b0 || pc !== RST_PC)
         $display("FAIL mis_halt got v=%0b pc=%h want v=0 pc=%h", fetch_valid, pc, RST_PC);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         commit_valid = 1; trap_valid = i[0]; trap_pc = 32'h8000_2000; fetch_ready = 1; tick();
      end
      clear_inputs();
      total_cnt++; if (fetch_valid !== 1'b0 || pc !== RST_PC || misalign !== 1'b1 || retire_cnt !== 64'd0)
         $display("FAIL halt_ignore got v=%0b pc=%h mis=%0b cnt=%0d want v=0 pc=%h mis=1 cnt=0", fetch_valid, pc, misalign, retire_cnt, RST_PC);
      else pass_cnt++;
      do_reset();
      total_cnt++; if (misalign !== 1'b0 || fetch_valid !== 1'b1)
         $display("FAIL halt_exit got mis=%0b v=%0b want mis=0 v=1", misalign, fetch_valid);
      else pass_cnt++;
`else
      total_cnt++; if (pc !== 32'h8000_0002) $display("FAIL misaligned_load got %h want 80000002", pc); else pass_cnt++;
      total_cnt++; if (fetch_valid !== 1'b1) $display("FAIL misaligned_fetch got %0b want 1", fetch_valid); else pass_cnt++;
`endif
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if (m_halt || $urandom_range(0, 99) < 2) begin
            clear_inputs();
            rst = 1; #1;
            total_cnt++;
            if (pc !== RST_PC || fetch_valid !== 1'b1) begin
               errs++; $display("FAIL rand_async_reset i=%0d got pc=%h v=%0b", i, pc, fetch_valid);
            end else pass_cnt++;
            tick(); rst = 0;
         end
         fetch_ready  = ($urandom_range(0, 3) != 0);
         commit_valid = ($urandom_range(0, 2) != 0);
         trap_valid   = ($urandom_range(0, 7) == 0);
         PCActr       = $urandom_range(0, 1);
         PCBctr       = $urandom_range(0, 1);
         imm          = $urandom;
         rs1          = $urandom;
         trap_pc      = $urandom & ~32'd3;
         if ($urandom_range(0, 9) != 0) begin
            imm = imm & ~32'd3; rs1 = rs1 & ~32'd3;
         end
         tick();
         total_cnt++;
         if (pc !== m_pc || fetch_pc !== m_pc || snpc !== m_pc + 32'd4 || fetch_valid !== (m_fetch && !m_halt)
             || retire_cnt !== m_cnt
`ifdef YSYX_24100027_PCU_ALIGN_CHK_EN
             || misalign !== m_mis
`endif
            ) begin
            errs++;
            if (errs < 10)
               $display("FAIL rand_cycle i=%0d got pc=%h fpc=%h snpc=%h v=%0b cnt=%0d want pc=%h v=%0b cnt=%0d",
                        i, pc, fetch_pc, snpc, fetch_valid, retire_cnt, m_pc, m_fetch && !m_halt, m_cnt);
         end else pass_cnt++;
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_sequential();
      test_branch();
      test_wrap();
      test_trap_priority();
      test_misalign();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ysyx_24100027_pcunit.md
# ysyx_24100027_pcunit

Program-counter unit for the multi-cycle NPC core: holds the architectural PC, issues instruction-fetch requests to the IFU over a valid/ready handshake, and computes the next PC when execute commits an instruction. It sits directly downstream of the branch controller and consumes its PCActr/PCBctr select pair together with the immediate and rs1 operands. It also carries the trap-redirect path and a retired-instruction counter.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded by reset
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- PCActr  in  1  adder operand A select: 1 = imm, 0 = constant 4
- PCBctr  in  1  adder operand B select: 1 = rs1 (jalr path), 0 = current pc
- imm  in  32  sign-extended immediate of the committing instruction
- rs1  in  32  rs1 value of the committing instruction
- commit_valid  in  1  execute retires the fetched instruction; PCActr/PCBctr/imm/rs1 valid this cycle
- trap_valid  in  1  redirect to trap_pc (ecall/mret/exception)
- trap_pc  in  32  trap redirect target
- fetch_ready  in  1  IFU accepts fetch_pc
- fetch_valid  out  1  fetch request pending
- fetch_pc  out  32  address to fetch (equals pc)
- pc  out  32  PC of the instruction in flight
- snpc  out  32  pc + 4 (link value for jal/jalr)
- retire_cnt  out  64  count of commits accepted since reset
- misalign  out  1  sticky misaligned-target flag (present only with YSYX_24100027_PCU_ALIGN_CHK_EN)

## Operation
- States: FETCH, WAIT, HALT (HALT reachable only with the macro).
- Reset (asynchronous, any state, mid-handshake included): pc = RESET_PC, state = FETCH, fetch_valid = 1, retire_cnt = 0, misalign = 0.
- FETCH: fetch_valid = 1, fetch_pc = pc held stable until fetch_valid & fetch_ready; on handshake -> WAIT. commit_valid / trap_valid in FETCH are ignored (no state, pc or counter change).
- WAIT: fetch_valid = 0. trap_valid has priority: pc <= trap_pc, -> FETCH, retire_cnt unchanged. Else commit_valid: pc <= dnpc, retire_cnt += 1, -> FETCH. Neither: hold.
- dnpc = (PCActr ? imm : 32'd4) + (PCBctr ? rs1 : pc), modulo 2^32 (wrap, no carry out); when PCBctr = 1, dnpc[0] is forced to 0. Combination PCActr=0, PCBctr=1 yields (rs1+4) with bit 0 cleared; defined, not produced by the branch controller.
- snpc = pc + 4, modulo 2^32, combinational from pc.
- retire_cnt wraps from 2^64-1 to 0.

## Timing
- Fetch handshake in cycle n -> fetch_valid low from n+1.
- commit_valid or trap_valid in WAIT at cycle n -> new pc and fetch_valid = 1 visible at n+1 (one-cycle redirect latency); retire_cnt updated at n+1.
- Minimum instruction period: 2 cycles (FETCH with fetch_ready already high, then WAIT with immediate commit).
- All outputs registered except snpc and fetch_pc (wire of pc).

## Configuration
- YSYX_24100027_PCU_ALIGN_CHK_EN defined: on commit in WAIT, if dnpc[1:0] != 2'b00 then pc unchanged, retire_cnt unchanged, -> HALT, misalign = 1. HALT: fetch_valid = 0, all inputs ignored, exit only by rst. trap_pc is not checked; trap_valid in WAIT still redirects with priority.
- Undefined: no misalign port, no HALT state; dnpc loaded unconditionally, including misaligned values.

## Test plan
- Reset with fetch_ready=0 -> fetch_valid=1, fetch_pc=0x8000_0000, retire_cnt=0; fetch_pc stable across 5 stalled cycles; rst asserted in WAIT -> FETCH, pc=0x8000_0000 immediately.
- Sequential: handshake, commit with PCActr=0,PCBctr=0 -> next fetch_pc=0x8000_0004 one cycle later, retire_cnt=1; snpc=0x8000_0008.
- Branch taken: pc=0x8000_0010, PCActr=1, imm=0xFFFF_FFF0 -> pc=0x8000_0000; jalr: PCActr=1,PCBctr=1, rs1=0x8000_0101, imm=4 -> pc=0x8000_0104 (bit 0 cleared).
- Wrap: pc=0xFFFF_FFFC, sequential commit -> pc=0x0000_0000; snpc at pc=0xFFFF_FFFC = 0x0000_0000.
- Simultaneous trap_valid and commit_valid in WAIT, trap_pc=0x8000_1000 -> pc=0x8000_1000, retire_cnt unchanged; same pulse during FETCH -> no effect.
- Macro on: jalr to rs1=0x8000_0002, imm=0 -> misalign=1, HALT, fetch_valid=0, pc unchanged; later commits/traps ignored until rst. Macro off: same stimulus -> pc=0x8000_0002, fetch_valid=1.
